// File: rtl/qe_sim_generator.sv
// Quadrature encoder simulator: produces A/B (and optional index) channels
// with a programmable per-state period, continuous or burst operation, and
// a signed step position counter.
// Optional feature: define QE_SIM_INDEX_EN to enable the pulse counter and
// the QE_I index channel; without it QE_I is tied low and pulses_per_rev
// is ignored.
module qe_sim_generator #(
    parameter int unsigned TIMER_WIDTH = 16,
    parameter int unsigned PULSE_WIDTH = 16,
    parameter int unsigned POS_WIDTH   = 32
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic                        QE_sim_enable,
    input  logic                        direction,
    input  logic                        burst_mode,
    input  logic [TIMER_WIDTH-1:0]      phase_period,
    input  logic [PULSE_WIDTH-1:0]      pulses_per_rev,
    input  logic [PULSE_WIDTH-1:0]      burst_steps,
    output logic                        QE_A,
    output logic                        QE_B,
    output logic                        QE_I,
    output logic signed [POS_WIDTH-1:0] position,
    output logic                        busy,
    output logic                        done
);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_LOAD   = 2'd1,
        S_TIMING = 2'd2,
        S_STEP   = 2'd3
    } state_t;

    state_t                 state;
    logic [TIMER_WIDTH-1:0] timer;
    logic [TIMER_WIDTH-1:0] period_q;
    logic                   dir_q;
    logic                   burst_q;
    logic [PULSE_WIDTH-1:0] steps_q;
    logic [PULSE_WIDTH-1:0] step_cnt;
    logic [PULSE_WIDTH-1:0] step_cnt_next;
    logic [1:0]             ab_cur;
    logic [1:0]             ab_next;
    logic                   burst_last;

    assign ab_cur        = {QE_A, QE_B};
    assign step_cnt_next = step_cnt + PULSE_WIDTH'(1);
    assign burst_last    = burst_q && (step_cnt_next == steps_q);

    // Next Gray code state in the latched direction
    always_comb begin
        ab_next = ab_cur;
        if (dir_q) begin
            case (ab_cur)
                2'b00:   ab_next = 2'b10;
                2'b10:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b01;
                default: ab_next = 2'b00;
            endcase
        end else begin
            case (ab_cur)
                2'b00:   ab_next = 2'b01;
                2'b01:   ab_next = 2'b11;
                2'b11:   ab_next = 2'b10;
                default: ab_next = 2'b00;
            endcase
        end
    end

    // Control FSM with registered channel, position, busy and done outputs
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state    <= S_IDLE;
            timer    <= '0;
            period_q <= '0;
            dir_q    <= 1'b0;
            burst_q  <= 1'b0;
            steps_q  <= '0;
            step_cnt <= '0;
            QE_A     <= 1'b0;
            QE_B     <= 1'b0;
            position <= '0;
            busy     <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= 1'b0;
            case (state)
                S_IDLE: begin
                    if (QE_sim_enable) begin
                        state <= S_LOAD;
                        busy  <= 1'b1;
                    end
                end
                S_LOAD: begin
                    dir_q    <= direction;
                    burst_q  <= burst_mode;
                    period_q <= phase_period;
                    steps_q  <= burst_steps;
                    timer    <= phase_period;
                    step_cnt <= '0;
                    if (burst_mode && (burst_steps == '0)) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else begin
                        state <= S_TIMING;
                    end
                end
                S_TIMING: begin
                    if (!QE_sim_enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else if (timer == '0) begin
                        state <= S_STEP;
                    end else begin
                        timer <= timer - TIMER_WIDTH'(1);
                    end
                end
                S_STEP: begin
                    QE_A     <= ab_next[1];
                    QE_B     <= ab_next[0];
                    position <= dir_q ? position + POS_WIDTH'(1)
                                      : position - POS_WIDTH'(1);
                    timer    <= period_q;
                    step_cnt <= step_cnt_next;
                    // A finishing burst wins over a simultaneous enable drop
                    if (burst_last) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                        done  <= 1'b1;
                    end else if (!QE_sim_enable) begin
                        state <= S_IDLE;
                        busy  <= 1'b0;
                    end else begin
                        state <= S_TIMING;
                    end
                end
                default: begin
                    state <= S_IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

`ifdef QE_SIM_INDEX_EN
    logic [PULSE_WIDTH-1:0] ppr_q;
    logic [PULSE_WIDTH-1:0] ppr_last;
    logic [PULSE_WIDTH-1:0] pulse_cnt;
    logic [PULSE_WIDTH-1:0] pulse_next;

    // Highest pulse count value; a zero pulses_per_rev behaves as one
    assign ppr_last = (ppr_q == '0) ? '0 : ppr_q - PULSE_WIDTH'(1);

    // Pulse counter advances on forward entry to 00, retreats on reverse exit from 00
    always_comb begin
        pulse_next = pulse_cnt;
        if (dir_q) begin
            if (ab_next == 2'b00) begin
                pulse_next = (pulse_cnt >= ppr_last) ? '0 : pulse_cnt + PULSE_WIDTH'(1);
            end
        end else if (ab_cur == 2'b00) begin
            pulse_next = ((pulse_cnt == '0) || (pulse_cnt > ppr_last))
                       ? ppr_last : pulse_cnt - PULSE_WIDTH'(1);
        end
    end

    // Index channel and pulse counter, updated together with A/B
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ppr_q     <= '0;
            pulse_cnt <= '0;
            QE_I      <= 1'b0;
        end else if (state == S_LOAD) begin
            ppr_q <= pulses_per_rev;
        end else if (state == S_STEP) begin
            pulse_cnt <= pulse_next;
            QE_I      <= (ab_next == 2'b00) && (pulse_next == '0);
        end
    end
`else
    logic unused_ppr;

    assign unused_ppr = ^pulses_per_rev;
    assign QE_I       = 1'b0;
`endif

endmodule

// File: doc/qe_sim_generator.md
QE_SIM_GENERATOR -- requirements
Module: qe_sim_generator

Interface
REQ-001 SHALL have parameter TIMER_WIDTH, default 16, width of phase_period and phase timer.
REQ-002 SHALL have parameter PULSE_WIDTH, default 16, width of pulses_per_rev, burst_steps and pulse counter.
REQ-003 SHALL have parameter POS_WIDTH, default 32, width of the signed position counter.
REQ-004 SHALL have ports as follows; one clock, reset asynchronous active-low:
- clk  input  1  system clock, all state on rising edge
- reset  input  1  asynchronous active-low reset
- QE_sim_enable  input  1  run request
- direction  input  1  1 = forward (A leads B), 0 = reverse
- burst_mode  input  1  0 = continuous, 1 = stop after burst_steps steps
- phase_period  input  TIMER_WIDTH  extra cycles per quadrature state
- pulses_per_rev  input  PULSE_WIDTH  pulses between index marks
- burst_steps  input  PULSE_WIDTH  quadrature steps per burst
- QE_A, QE_B, QE_I  output  1  simulated encoder channels
- position  output  POS_WIDTH  signed step count
- busy  output  1  high in any state except S_IDLE
- done  output  1  one-cycle pulse at burst completion

Function
REQ-005 SHALL implement a Moore FSM with states S_IDLE, S_LOAD, S_TIMING, S_STEP.
REQ-006 S_IDLE -> S_LOAD when QE_sim_enable = 1, else stay.
REQ-007 S_LOAD (1 cycle) SHALL latch direction, burst_mode, phase_period, pulses_per_rev, burst_steps; load timer = phase_period; -> S_TIMING, or -> S_IDLE with done = 1 if burst_mode = 1 and burst_steps = 0.
REQ-008 S_TIMING: timer = 0 -> S_STEP, else decrement; QE_sim_enable = 0 -> S_IDLE (abort, no done, outputs hold).
REQ-009 S_STEP (1 cycle) SHALL advance {QE_A,QE_B} one Gray step (forward 00->10->11->01->00; reverse opposite), update position +1/-1, reload timer with latched phase_period.
REQ-010 After S_STEP: burst complete (step count = latched burst_steps) -> S_IDLE with done = 1; QE_sim_enable = 0 -> S_IDLE; else -> S_TIMING.
REQ-011 Quadrature state duration SHALL be phase_period + 2 cycles; phase_period = 0 gives 2-cycle states.
REQ-012 Outputs QE_A, QE_B, QE_I, position SHALL be registered and change only on the edge leaving S_STEP.
REQ-013 Pulse counter SHALL increment when forward step lands on {A,B} = 00, wrapping pulses_per_rev-1 -> 0; reverse decrements when leaving 00, wrapping 0 -> pulses_per_rev-1.
REQ-014 pulses_per_rev = 0 SHALL be treated as 1 (index every pulse).
REQ-015 position SHALL wrap two's-complement with no saturation.
REQ-016 Direction and period changes SHALL take effect only at next S_LOAD; A/B phase is preserved across runs (not reset on re-enable).
REQ-017 done SHALL be a single-cycle pulse; busy SHALL be 0 in the cycle done is high's successor state S_IDLE.

Reset
REQ-018 On reset low: state S_IDLE, QE_A = QE_B = QE_I = 0, position = 0, pulse and step counters = 0, timer = 0, busy = 0, done = 0.
REQ-019 Reset asserted mid-run SHALL abort immediately with no done pulse.

Configuration
REQ-020 Macro QE_SIM_INDEX_EN defined: pulse counter and QE_I active; QE_I = 1 while {A,B} = 00 and pulse counter = 0, else 0.
REQ-021 QE_SIM_INDEX_EN undefined: pulse counter omitted, QE_I tied 0, pulses_per_rev ignored.

Verification
REQ-022 Forward, continuous, phase_period = 2: A/B sequence 00,10,11,01,00 with each state 4 cycles; position 0 -> 4.
REQ-023 Reverse, burst_mode = 1, burst_steps = 3: sequence 00,01,11,10, position = -3, done one cycle, busy low next cycle.
REQ-024 With QE_SIM_INDEX_EN, pulses_per_rev = 2, forward 16 steps: QE_I high during states at position 8 and 16 only (pulse counter back to 0).
REQ-025 burst_mode = 1, burst_steps = 0: done in cycle after S_LOAD, A/B and position unchanged.
REQ-026 Drop QE_sim_enable mid-S_TIMING, then reset mid-run: first returns to S_IDLE with outputs held, no done; reset clears all outputs to 0.
